// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file with ecall/ebreak/mret redirect FSM
// Define CSR_COUNTERS_EN to include the mcycle/minstret counters.
module csr_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_w,
  input  logic        csr_data_s,
  input  logic        sys,
  input  logic [11:0] imm12,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  input  logic [31:0] pc,
  input  logic        retire,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;

  state_e      state_q;
  logic        redirect_q;
  logic [31:0] redirect_pc_q;

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:2] mtvec_q, mtvec_d;
  logic [31:2] mepc_q, mepc_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mcause_q, mcause_d;

  logic        run;
  logic        is_ecall;
  logic        is_ebreak;
  logic        is_mret;
  logic        take_trap;
  logic        do_write;
  logic [31:0] wdata;

  // A SYSTEM op or CSR write arriving while in FLUSH sits in a squashed slot.
  assign run       = (state_q == RUN);
  assign is_ecall  = run & sys & (imm12 == 12'h000);
  assign is_ebreak = run & sys & (imm12 == 12'h001);
  assign is_mret   = run & sys & (imm12 == 12'h302);
  assign take_trap = is_ecall | is_ebreak;
  assign do_write  = run & csr_w & ~sys;
  assign wdata     = csr_data_s ? {27'b0, zimm} : rs1_data;

`ifdef CSR_COUNTERS_EN
  logic [31:0] mcycle_q, mcycle_d;
  logic [31:0] minstret_q, minstret_d;
  logic        unused_ok;
  assign unused_ok = ^pc[1:0];
`else
  logic        unused_ok;
  assign unused_ok = ^{pc[1:0], retire};
`endif

  always_comb begin
    csr_rdata = 32'b0;
    case (imm12)
      ADDR_MSTATUS:  csr_rdata = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
      ADDR_MTVEC:    csr_rdata = {mtvec_q, 2'b00};
      ADDR_MSCRATCH: csr_rdata = mscratch_q;
      ADDR_MEPC:     csr_rdata = {mepc_q, 2'b00};
      ADDR_MCAUSE:   csr_rdata = mcause_q;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE:   csr_rdata = mcycle_q;
      ADDR_MINSTRET: csr_rdata = minstret_q;
`endif
      default:       csr_rdata = 32'b0;
    endcase
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mscratch_d = mscratch_q;
    mcause_d   = mcause_q;
    if (take_trap) begin
      mepc_d   = pc[31:2];
      mcause_d = is_ecall ? 32'd11 : 32'd3;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (is_mret) begin
      mie_d    = mpie_q;
      mpie_d   = 1'b1;
    end else if (do_write) begin
      case (imm12)
        ADDR_MSTATUS: begin
          mie_d  = wdata[3];
          mpie_d = wdata[7];
        end
        ADDR_MTVEC:    mtvec_d    = wdata[31:2];
        ADDR_MSCRATCH: mscratch_d = wdata;
        ADDR_MEPC:     mepc_d     = wdata[31:2];
        ADDR_MCAUSE:   mcause_d   = wdata;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  // An explicit CSR write overrides the increment on the same edge.
  always_comb begin
    mcycle_d   = mcycle_q + 32'd1;
    minstret_d = minstret_q + {31'b0, run & retire};
    if (do_write && imm12 == ADDR_MCYCLE)   mcycle_d   = wdata;
    if (do_write && imm12 == ADDR_MINSTRET) minstret_d = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= 32'b0;
      minstret_q <= 32'b0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= 30'b0;
      mepc_q     <= 30'b0;
      mscratch_q <= 32'b0;
      mcause_q   <= 32'b0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mscratch_q <= mscratch_d;
      mcause_q   <= mcause_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'b0;
    end else begin
      case (state_q)
        RUN: begin
          redirect_q <= 1'b0;
          if (take_trap) begin
            redirect_q    <= 1'b1;
            redirect_pc_q <= {mtvec_q, 2'b00};
            state_q       <= FLUSH;
          end else if (is_mret) begin
            redirect_q    <= 1'b1;
            redirect_pc_q <= {mepc_q, 2'b00};
            state_q       <= FLUSH;
          end
        end
        FLUSH: begin
          redirect_q <= 1'b0;
          state_q    <= RUN;
        end
        default: begin
          redirect_q <= 1'b0;
          state_q    <= RUN;
        end
      endcase
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed table, corner sequences and random run against a CSR map model
// Honours CSR_COUNTERS_EN the same way as the design.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_w = 1'b0;
  logic        csr_data_s = 1'b0;
  logic        sys = 1'b0;
  logic [11:0] imm12 = 12'h0;
  logic [31:0] rs1_data = 32'h0;
  logic [4:0]  zimm = 5'h0;
  logic [31:0] pc = 32'h0;
  logic        retire = 1'b0;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;

  csr_file dut (
    .clk(clk), .rst_n(rst_n), .csr_w(csr_w), .csr_data_s(csr_data_s), .sys(sys),
    .imm12(imm12), .rs1_data(rs1_data), .zimm(zimm), .pc(pc), .retire(retire),
    .csr_rdata(csr_rdata), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: a map of implemented CSR addresses to architectural values.
  logic [31:0] csr_m [logic [11:0]];
  bit          m_flush;

  typedef struct packed {
    logic        w, s, sy;
    logic [11:0] imm;
    logic [31:0] rs1;
    logic [4:0]  z;
    logic [31:0] p;
    logic [31:0] e_rd;
    logic        e_r;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    csr_m.delete();
    csr_m[12'h300] = 0; csr_m[12'h305] = 0; csr_m[12'h340] = 0;
    csr_m[12'h341] = 0; csr_m[12'h342] = 0;
`ifdef CSR_COUNTERS_EN
    csr_m[12'hB00] = 0; csr_m[12'hB02] = 0;
`endif
    m_flush = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    return csr_m.exists(a) ? csr_m[a] : 32'h0;
  endfunction

  function automatic logic [31:0] wmask(input logic [11:0] a);
    if (a == 12'h300) return 32'h0000_0088;
    if (a == 12'h305 || a == 12'h341) return 32'hFFFF_FFFC;
    return 32'hFFFF_FFFF;
  endfunction

  // One clock: drive, check combinational read, advance model, check registered redirect.
  task automatic apply(input logic w, input logic s, input logic sy, input logic [11:0] imm,
                       input logic [31:0] rs1, input logic [4:0] z, input logic [31:0] p,
                       input logic ret, input string tag,
                       output logic [31:0] rd, output logic r, output logic [31:0] rpc);
    logic [31:0] wd, ms, cyc, ins;
    logic        exp_r;
    logic [31:0] exp_pc;
    csr_w = w; csr_data_s = s; sys = sy; imm12 = imm; rs1_data = rs1; zimm = z; pc = p; retire = ret;
    #1;
    rd = csr_rdata;
    check({tag, " rdata"}, rd, model_read(imm));
    wd = s ? {27'b0, z} : rs1;
    exp_r = 0; exp_pc = 0;
    cyc = model_read(12'hB00) + 1;
    ins = model_read(12'hB02) + ((ret && !m_flush) ? 1 : 0);
    if (!m_flush) begin
      if (sy && (imm == 12'h000 || imm == 12'h001)) begin
        ms = csr_m[12'h300];
        csr_m[12'h341] = p & 32'hFFFF_FFFC;
        csr_m[12'h342] = (imm == 12'h000) ? 32'd11 : 32'd3;
        csr_m[12'h300] = ms[3] ? 32'h80 : 32'h0;
        exp_r = 1; exp_pc = csr_m[12'h305];
      end else if (sy && imm == 12'h302) begin
        ms = csr_m[12'h300];
        csr_m[12'h300] = 32'h80 | (ms[7] ? 32'h08 : 32'h0);
        exp_r = 1; exp_pc = csr_m[12'h341];
      end
    end
`ifdef CSR_COUNTERS_EN
    csr_m[12'hB00] = cyc;
    csr_m[12'hB02] = ins;
`endif
    if (!m_flush && !sy && w && csr_m.exists(imm)) csr_m[imm] = wd & wmask(imm);
    m_flush = exp_r;
    @(posedge clk);
    #1;
    r = redirect;
    rpc = redirect_pc;
    check({tag, " redirect"}, {31'b0, r}, {31'b0, exp_r});
    if (exp_r) check({tag, " redirect_pc"}, rpc, exp_pc);
  endtask

  task automatic add(input logic w, input logic s, input logic sy, input logic [11:0] imm,
                     input logic [31:0] rs1, input logic [4:0] z, input logic [31:0] p,
                     input logic [31:0] e_rd, input logic e_r, input logic [31:0] e_pc);
    tbl.push_back({w, s, sy, imm, rs1, z, p, e_rd, e_r, e_pc});
  endtask

  logic [31:0] rd, rpc;
  logic        r;
  logic [11:0] addrs [11];

  initial begin
    model_reset();
    //  w  s  sys imm       rs1           zimm   pc     exp_rd        redir exp_pc
    add(1, 1, 0, 12'h305, 32'h0,        5'h10, 32'h0,  32'h0,        0, 32'h0);
    add(0, 0, 0, 12'h305, 32'h0,        5'h0,  32'h0,  32'h10,       0, 32'h0);
    add(1, 0, 0, 12'h305, 32'h103,      5'h0,  32'h0,  32'h10,       0, 32'h0);
    add(1, 0, 0, 12'h300, 32'hFFFF_FF88,5'h0,  32'h0,  32'h0,        0, 32'h0);
    add(0, 0, 0, 12'h300, 32'h0,        5'h0,  32'h0,  32'h88,       0, 32'h0);
    add(0, 0, 1, 12'h000, 32'h0,        5'h0,  32'h40, 32'h0,        1, 32'h100);
    add(0, 0, 1, 12'h000, 32'h0,        5'h0,  32'h80, 32'h0,        0, 32'h0);
    add(0, 0, 0, 12'h341, 32'h0,        5'h0,  32'h0,  32'h40,       0, 32'h0);
    add(0, 0, 0, 12'h342, 32'h0,        5'h0,  32'h0,  32'd11,       0, 32'h0);
    add(0, 0, 0, 12'h300, 32'h0,        5'h0,  32'h0,  32'h80,       0, 32'h0);
    add(0, 0, 1, 12'h302, 32'h0,        5'h0,  32'h0,  32'h0,        1, 32'h40);
    add(0, 0, 0, 12'h300, 32'h0,        5'h0,  32'h0,  32'h88,       0, 32'h0);
    add(0, 0, 1, 12'h001, 32'h0,        5'h0,  32'h44, 32'h0,        1, 32'h100);
    add(1, 0, 0, 12'h340, 32'hDEAD_BEEF,5'h0,  32'h0,  32'h0,        0, 32'h0);
    add(0, 0, 0, 12'h342, 32'h0,        5'h0,  32'h0,  32'd3,        0, 32'h0);
    add(0, 0, 0, 12'h340, 32'h0,        5'h0,  32'h0,  32'h0,        0, 32'h0);
    add(0, 0, 1, 12'h105, 32'h0,        5'h0,  32'h0,  32'h0,        0, 32'h0);
    add(1, 0, 1, 12'h340, 32'h1234,     5'h0,  32'h0,  32'h0,        0, 32'h0);
    add(0, 0, 0, 12'h340, 32'h0,        5'h0,  32'h0,  32'h0,        0, 32'h0);
    add(1, 0, 0, 12'h341, 32'h1237,     5'h0,  32'h0,  32'h44,       0, 32'h0);
    add(0, 0, 0, 12'h341, 32'h0,        5'h0,  32'h0,  32'h1234,     0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    imm12 = 12'h300;
    #1;
    check("reset redirect", {31'b0, redirect}, 32'h0);
    check("reset redirect_pc", redirect_pc, 32'h0);
    check("reset mstatus", csr_rdata, 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].w, tbl[i].s, tbl[i].sy, tbl[i].imm, tbl[i].rs1, tbl[i].z, tbl[i].p, 1'b0,
            $sformatf("tbl%0d", i), rd, r, rpc);
      check($sformatf("tbl%0d const rdata", i), rd, tbl[i].e_rd);
      check($sformatf("tbl%0d const redirect", i), {31'b0, r}, {31'b0, tbl[i].e_r});
      if (tbl[i].e_r) check($sformatf("tbl%0d const redirect_pc", i), rpc, tbl[i].e_pc);
    end

    // Counter write then wrap on the following edge.
    apply(1, 0, 0, 12'hB00, 32'hFFFF_FFFF, 5'h0, 32'h0, 1'b0, "cyc_wr", rd, r, rpc);
    apply(0, 0, 0, 12'hB00, 32'h0, 5'h0, 32'h0, 1'b0, "cyc_rd1", rd, r, rpc);
`ifdef CSR_COUNTERS_EN
    check("mcycle written", rd, 32'hFFFF_FFFF);
`else
    check("mcycle absent", rd, 32'h0);
`endif
    apply(0, 0, 0, 12'hB00, 32'h0, 5'h0, 32'h0, 1'b0, "cyc_rd2", rd, r, rpc);
    check("mcycle wrap", rd, 32'h0);

    // Reset asserted while in FLUSH takes effect without a clock edge.
    apply(0, 0, 1, 12'h000, 32'h0, 5'h0, 32'h88, 1'b0, "pre_rst_ecall", rd, r, rpc);
    check("pre_rst redirect", {31'b0, r}, 32'h1);
    csr_w = 0; sys = 0; imm12 = 12'h341;
    rst_n = 1'b0;
    #1;
    check("async rst redirect", {31'b0, redirect}, 32'h0);
    check("async rst redirect_pc", redirect_pc, 32'h0);
    check("async rst mepc", csr_rdata, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(0, 0, 1, 12'h000, 32'h0, 5'h0, 32'h20, 1'b0, "post_rst_ecall", rd, r, rpc);
    check("post_rst redirect", {31'b0, r}, 32'h1);

    addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
              12'hB02, 12'h000, 12'h001, 12'h302, 12'h123};
    for (int k = 0; k < 600; k++) begin
      logic        rw, rsy;
      logic [11:0] ra;
      rsy = ($urandom_range(0, 5) == 0);
      rw  = $urandom_range(0, 1);
      ra  = addrs[$urandom_range(0, 10)];
      apply(rw, 1'($urandom_range(0, 1)), rsy, ra, $urandom, 5'($urandom), $urandom,
            1'($urandom_range(0, 1)), $sformatf("rnd%0d", k), rd, r, rpc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
